mem_swap_engine: RTL
====================

MEM_SWAP_ENGINE -- requirements
Module: mem_swap_engine

Interface
REQ-001 SHALL have parameter N, default 7, address width; depth = 2**N words.
REQ-002 SHALL have parameter BITS, default 8, data word width.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port we  input  1  host write enable.
REQ-006 SHALL have port address_w  input  N  host write address.
REQ-007 SHALL have port data_w  input  BITS  host write data.
REQ-008 SHALL have port address_r  input  N  host read address.
REQ-009 SHALL have port data_r  output  BITS  registered host read data.
REQ-010 SHALL have port op_valid  input  1  operation request valid.
REQ-011 SHALL have port op_ready  output  1  engine can accept a request.
REQ-012 SHALL have port op_mode  input  2  00 SWAP, 01 COPY A->B, 10 ZERO A, 11 reserved.
REQ-013 SHALL have port address_A  input  N  first operand address.
REQ-014 SHALL have port address_B  input  N  second operand address.
REQ-015 SHALL have port busy  output  1  operation in progress.
REQ-016 SHALL have port done  output  1  one-cycle pulse at operation completion.
REQ-017 SHALL have port op_err  output  1  pulses with done when the completed op was reserved mode.
REQ-018 SHALL have port wr_blocked  output  1  one-cycle pulse when a host write is dropped.

Function
REQ-019 SHALL accept a request on a cycle where op_valid and op_ready are both 1, capturing op_mode, address_A, address_B.
REQ-020 SHALL implement FSM IDLE -> CAPTURE -> COMMIT -> DONE -> IDLE, with exactly one cycle in each non-IDLE state.
REQ-021 SHALL drive op_ready = 1 only in IDLE, and busy = 1 in CAPTURE, COMMIT and DONE.
REQ-022 SHALL, in CAPTURE, latch tmpA = mem[A] and tmpB = mem[B].
REQ-023 SHALL, in COMMIT, write mem[A] = tmpB and mem[B] = tmpA for SWAP; mem[B] = tmpA for COPY; mem[A] = 0 for ZERO; nothing for reserved.
REQ-024 SHALL assert done for the single cycle the FSM is in DONE, which is 3 cycles after the accepting edge; the new contents are visible from DONE onward.
REQ-025 SHALL perform A == B as a normal operation with unchanged stored data for SWAP and COPY, full latency, and a done pulse.
REQ-026 SHALL assert op_err together with done for reserved op_mode, with memory unchanged.
REQ-027 SHALL perform a host write mem[address_w] = data_w when we = 1 and busy = 0.
REQ-028 SHALL drop any host write issued while busy = 1, and pulse wr_blocked on the following cycle.
REQ-029 SHALL register the read as data_r = mem[address_r] one cycle after address_r is presented; this is read-before-write, so a same-cycle write or commit returns the old value.
REQ-030 SHALL ignore op_valid while busy; a request held high across DONE is accepted on the first IDLE cycle.

Reset
REQ-031 SHALL, on reset, clear all memory words to 0, set FSM = IDLE, and clear data_r, tmpA, tmpB, done, op_err and wr_blocked to 0; op_ready = 1 and busy = 0 on the first cycle after reset.
REQ-032 SHALL abort any in-flight operation on reset, including one in COMMIT, with no partial write and no done pulse.

Structure
REQ-033 SHALL place the op_mode encodings and the FSM state encodings in the shared package mem_swap_pkg.
REQ-034 SHALL implement storage as sub-module mem_swap_array: a register array with one host write port, two engine write ports, three read ports and synchronous clear.

Verification (N=7, BITS=8)
REQ-035 SHALL cover: write mem[i] = i for i = 0..99, then read addresses 20..49 -> data_r = address one cycle later.
REQ-036 SHALL cover: SWAP A=1, B=2 -> done on the 3rd edge after accept; then mem[1]=2, mem[2]=1; op_ready low for 3 cycles.
REQ-037 SHALL cover: COPY A=5, B=9 then ZERO A=5 -> mem[9]=5, mem[5]=0; reserved mode A=3 -> op_err=1 with done and mem[3]=3.
REQ-038 SHALL cover: host write address 7, data 0xAA during busy -> wr_blocked pulse and mem[7] still 7; SWAP A=B=4 -> mem[4]=4 with done pulse.
REQ-039 SHALL cover: reset asserted during COMMIT of SWAP 10/11 -> no done, all words 0 and op_ready=1 after reset.

Source files
------------

// File: rtl/mem_swap_pkg.sv
// Shared encodings for the memory swap engine: operation modes and FSM states.
package mem_swap_pkg;

  typedef enum logic [1:0] {
    OP_SWAP = 2'b00,
    OP_COPY = 2'b01,
    OP_ZERO = 2'b10,
    OP_RSVD = 2'b11
  } op_mode_t;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'b00,
    ST_CAPTURE = 2'b01,
    ST_COMMIT  = 2'b10,
    ST_DONE    = 2'b11
  } state_t;

endpackage

// File: rtl/mem_swap_array.sv
// Register-array storage: one host write port, two engine write ports,
// three combinational read ports and a synchronous clear of every word.
module mem_swap_array #(
  parameter int N    = 7,
  parameter int BITS = 8
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            host_we,
  input  logic [N-1:0]    host_addr,
  input  logic [BITS-1:0] host_data,
  input  logic            a_we,
  input  logic [N-1:0]    a_addr,
  input  logic [BITS-1:0] a_data,
  input  logic            b_we,
  input  logic [N-1:0]    b_addr,
  input  logic [BITS-1:0] b_data,
  input  logic [N-1:0]    rd_h_addr,
  output logic [BITS-1:0] rd_h_data,
  input  logic [N-1:0]    rd_a_addr,
  output logic [BITS-1:0] rd_a_data,
  input  logic [N-1:0]    rd_b_addr,
  output logic [BITS-1:0] rd_b_data
);

  localparam int DEPTH = 1 << N;

  logic [BITS-1:0] mem [DEPTH];

  // Word updates; the host port and the engine ports are never active together,
  // and when both engine ports hit one address they carry the same value.
  always_ff @(posedge clk) begin
    if (reset) begin
      // NOTE: every word must really be cleared on reset, so this array is built
      // from flops rather than a RAM macro that cannot be reset.
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      // NOTE: non-blocking assignments keep each word's old value visible to
      // every reader during this edge, which is what makes reads read-before-write.
      if (host_we) mem[host_addr] <= host_data;
      if (a_we)    mem[a_addr]    <= a_data;
      if (b_we)    mem[b_addr]    <= b_data;
    end
  end

  assign rd_h_data = mem[rd_h_addr];
  assign rd_a_data = mem[rd_a_addr];
  assign rd_b_data = mem[rd_b_addr];

endmodule

// File: rtl/mem_swap_engine.sv
// Memory swap engine: host read/write port plus a four-state operation FSM
// that swaps, copies or zeroes words; host writes are dropped while busy.
module mem_swap_engine
  import mem_swap_pkg::*;
#(
  parameter int N    = 7,
  parameter int BITS = 8
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            we,
  input  logic [N-1:0]    address_w,
  input  logic [BITS-1:0] data_w,
  input  logic [N-1:0]    address_r,
  output logic [BITS-1:0] data_r,
  input  logic            op_valid,
  output logic            op_ready,
  input  logic [1:0]      op_mode,
  input  logic [N-1:0]    address_A,
  input  logic [N-1:0]    address_B,
  output logic            busy,
  output logic            done,
  output logic            op_err,
  output logic            wr_blocked
);

  state_t          state;
  op_mode_t        mode;
  logic [N-1:0]    addr_a;
  logic [N-1:0]    addr_b;
  logic [BITS-1:0] tmp_a;
  logic [BITS-1:0] tmp_b;

  logic            host_we;
  logic            a_we;
  logic            b_we;
  logic [BITS-1:0] a_data;
  logic [BITS-1:0] rd_h_data;
  logic [BITS-1:0] rd_a_data;
  logic [BITS-1:0] rd_b_data;

  // Engine write-port controls, active only during COMMIT.
  always_comb begin
    // NOTE: defaults first so every path assigns every output and no latch is inferred.
    a_we   = 1'b0;
    b_we   = 1'b0;
    a_data = tmp_b;
    if (state == ST_COMMIT) begin
      unique case (mode)
        OP_SWAP: begin a_we = 1'b1; b_we = 1'b1; end
        OP_COPY: b_we = 1'b1;
        OP_ZERO: begin a_we = 1'b1; a_data = '0; end
        default: ;
      endcase
    end
  end

  assign host_we = we && !busy;

  mem_swap_array #(.N(N), .BITS(BITS)) u_array (
    .clk       (clk),
    .reset     (reset),
    .host_we   (host_we),
    .host_addr (address_w),
    .host_data (data_w),
    .a_we      (a_we),
    .a_addr    (addr_a),
    .a_data    (a_data),
    .b_we      (b_we),
    .b_addr    (addr_b),
    .b_data    (tmp_a),
    .rd_h_addr (address_r),
    .rd_h_data (rd_h_data),
    .rd_a_addr (addr_a),
    .rd_a_data (rd_a_data),
    .rd_b_addr (addr_b),
    .rd_b_data (rd_b_data)
  );

  // Registered host read port.
  always_ff @(posedge clk) begin
    if (reset) data_r <= '0;
    else       data_r <= rd_h_data;
  end

  // Operation FSM with registered handshake and status outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= ST_IDLE;
      mode       <= OP_SWAP;
      addr_a     <= '0;
      addr_b     <= '0;
      tmp_a      <= '0;
      tmp_b      <= '0;
      op_ready   <= 1'b1;
      busy       <= 1'b0;
      done       <= 1'b0;
      op_err     <= 1'b0;
      wr_blocked <= 1'b0;
    end else begin
      done       <= 1'b0;
      op_err     <= 1'b0;
      wr_blocked <= we && busy;
      unique case (state)
        ST_IDLE: begin
          if (op_valid) begin
            mode     <= op_mode_t'(op_mode);
            addr_a   <= address_A;
            addr_b   <= address_B;
            op_ready <= 1'b0;
            busy     <= 1'b1;
            state    <= ST_CAPTURE;
          end
        end
        ST_CAPTURE: begin
          tmp_a <= rd_a_data;
          tmp_b <= rd_b_data;
          state <= ST_COMMIT;
        end
        ST_COMMIT: begin
          done   <= 1'b1;
          op_err <= (mode == OP_RSVD);
          state  <= ST_DONE;
        end
        ST_DONE: begin
          op_ready <= 1'b1;
          busy     <= 1'b0;
          state    <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
